ddr_burst_access_ctrl: RTL
==========================

Name: ddr_burst_access_ctrl

Overview:
- Sits directly upstream of the single-port block RAM model (`sram`) in the DDR emulation path; it is the only driver of that RAM's `addr`, `rd_o_wr` and `i_data`.
- Converts one DDR column command (READ/WRITE, start column) into BL back-to-back single-beat RAM accesses, using DDR sequential burst ordering (wrap inside the BL-aligned block).
- Streams write beats in over a valid/ready handshake; streams read beats out with a valid/last pipeline matched to the RAM's 1-cycle read latency.

Parameters:
- WIDTH, 8, data beat width; must equal the RAM WIDTH.
- DEPTH, 2048, RAM words; AW = $clog2(DEPTH).
- BL, 8, burst length; power of two, 2..DEPTH.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_wr  in  1  1 = WRITE burst, 0 = READ burst.
- cmd_addr  in  AW  burst start word address.
- wr_valid  in  1  write beat present.
- wr_ready  out  1  write beat accepted when wr_valid && wr_ready.
- wr_data  in  WIDTH  write beat data.
- rd_valid  out  1  rd_data holds a read beat this cycle.
- rd_last  out  1  final beat of a read burst; qualified by rd_valid.
- rd_data  out  WIDTH  read beat data.
- busy  out  1  high when not IDLE or when a read beat is still in flight.
- sram_addr  out  AW  to RAM addr.
- sram_rd_o_wr  out  1  to RAM rd_o_wr; 1 = write.
- sram_i_data  out  WIDTH  to RAM i_data.
- sram_o_data  in  WIDTH  from RAM o_data.

Behaviour:
- States: IDLE, WRITE, READ. Beat counter `beat` is log2(BL') bits, where BL' is the active burst length. Base is latched from cmd_addr on accept.
- Beat address = {base[AW-1:log2 BL'], (base[log2 BL'-1:0] + beat) mod BL'}. Wrap stays within the aligned block. Example: BL=8, base=0x0D gives 0x0D,0x0E,0x0F,0x08..0x0C.
- IDLE:
  - cmd_ready=1, wr_ready=0, sram_rd_o_wr=0, sram_addr=cmd_addr.
  - On accept: beat:=0; go to WRITE if cmd_wr, else READ.
- WRITE:
  - cmd_ready=0, wr_ready=1, sram_addr=beat address, sram_i_data=wr_data.
  - sram_rd_o_wr = wr_valid, combinational, so the RAM writes on the same edge that accepts the beat.
  - Accepted beat: beat+1. Accepted beat with beat==BL'-1: go to IDLE.
  - wr_valid low: stall, no RAM write, beat held; there is no timeout.
- READ:
  - sram_rd_o_wr=0, sram_addr=beat address. One address per cycle, no stall, no backpressure on the read output.
  - beat==BL'-1: go to IDLE.
- Read pipeline:
  - rd_valid and rd_last are flops: rd_valid <= (state==READ); rd_last <= (state==READ && beat==BL'-1).
  - rd_data = sram_o_data, combinational.
  - First data appears 2 cycles after the accept edge; BL' consecutive rd_valid cycles follow.
- A new command may be accepted in the cycle rd_last is high (state is already IDLE). rd_data is meaningless whenever rd_valid=0, because IDLE performs don't-care RAM reads.
- busy = (state!=IDLE) | rd_valid.
- Reset, any state, mid-burst included:
  - state=IDLE, beat=0, rd_valid=0, rd_last=0.
  - The remaining burst is abandoned and RAM writes of beats already accepted stand.
  - Outputs after reset: cmd_ready=1, wr_ready=0, sram_rd_o_wr=0, busy=0.
- cmd_valid with invalid cmd fields outside IDLE is ignored; commands are never queued.

Optional Feature:
- Macro: DDR_BURST_CHOP_EN.
- Defined:
  - Adds input port cmd_bc4 (1 bit), sampled with the command.
  - If cmd_bc4=1 and BL==8, then BL'=4 and wrap is within the 4-aligned block.
  - Write accepts 4 beats; read emits 4 rd_valid beats with rd_last on the 4th.
  - cmd_bc4 is ignored when BL!=8.
- Not defined: no cmd_bc4 port; BL'=BL always.

Test Plan:
- Reset, then WRITE base=0x010 with data 0xA0..0xA7 and wr_valid continuous -> RAM 0x010..0x017 = 0xA0..0xA7; back in IDLE 8 cycles after accept; cmd_ready=1.
- READ base=0x013 after the above -> rd_valid 8 consecutive cycles, starting 2 cycles after accept, with data 0xA3,0xA4,0xA5,0xA6,0xA7,0xA0,0xA1,0xA2; rd_last only on 0xA2.
- WRITE base=0x020 with wr_valid deasserted for 3 cycles after beat 2 -> no RAM write during the gap; beat count resumes; all 8 words correct; sram_rd_o_wr=0 in the gap cycles.
- READ base=0x010 immediately followed by READ base=0x018, second accepted in the rd_last cycle of the first -> 16 valid beats with a single 1-cycle gap (first burst's rd_last cycle, then one IDLE cycle).
- rst asserted after 3 accepted write beats of base=0x030 -> 0x030..0x032 written, 0x033..0x037 unchanged (0); next cycle cmd_ready=1, busy=0, rd_valid=0.
- With DDR_BURST_CHOP_EN: WRITE cmd_bc4=1 base=0x046 with data 0x11..0x14 -> writes 0x046,0x047,0x044,0x045; exactly 4 beats accepted; IDLE after the 4th.

Source files
------------

// File: rtl/ddr_burst_access_ctrl.sv
// DDR column-command to single-port RAM burst sequencer: BL beats in sequential wrap order, 1-cycle read pipeline.
// Optional burst chop (BC4 when BL==8) is enabled by defining DDR_BURST_CHOP_EN.
module ddr_burst_access_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2048,
    parameter int BL    = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int LBL  = $clog2(BL)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_wr,
    input  logic [AW-1:0]    cmd_addr,
`ifdef DDR_BURST_CHOP_EN
    input  logic             cmd_bc4,
`endif
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    output logic             rd_valid,
    output logic             rd_last,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic [AW-1:0]    sram_addr,
    output logic             sram_rd_o_wr,
    output logic [WIDTH-1:0] sram_i_data,
    input  logic [WIDTH-1:0] sram_o_data
);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

    state_t           state, state_nxt;
    logic [AW-1:0]    base;
    logic [LBL-1:0]   beat;
    logic [LBL-1:0]   last_beat;
    logic [AW-1:0]    blk_mask;
    logic [AW-1:0]    beat_addr;
    logic             cmd_acc;
    logic             at_last;
    logic             vld_p1;
    logic             last_p1;

    assign cmd_acc = cmd_valid && cmd_ready;
    assign at_last = (beat == last_beat);

    // Low bits wrap inside the BL'-aligned block, high bits come straight from base.
    assign blk_mask  = AW'(last_beat);
    assign beat_addr = (base & ~blk_mask) | ((base + AW'(beat)) & blk_mask);

`ifdef DDR_BURST_CHOP_EN
    always_ff @(posedge clk) begin
        if (rst)
            last_beat <= LBL'(BL - 1);
        else if (cmd_acc)
            last_beat <= (BL == 8 && cmd_bc4) ? LBL'(3) : LBL'(BL - 1);
    end
`else
    assign last_beat = LBL'(BL - 1);
`endif

    always_ff @(posedge clk) begin
        if (cmd_acc)
            base <= cmd_addr;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (cmd_valid) state_nxt = cmd_wr ? S_WRITE : S_READ;
            S_WRITE: if (wr_valid && at_last) state_nxt = S_IDLE;
            S_READ:  if (at_last) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready    = 1'b0;
        wr_ready     = 1'b0;
        sram_rd_o_wr = 1'b0;
        sram_addr    = beat_addr;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                sram_addr = cmd_addr;
            end
            S_WRITE: begin
                wr_ready     = 1'b1;
                sram_rd_o_wr = wr_valid;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat <= '0;
        end else if (cmd_acc) begin
            beat <= '0;
        end else if ((state == S_WRITE && wr_valid) || state == S_READ) begin
            beat <= beat + LBL'(1);
        end
    end

    // Stage p1: RAM read data returns one cycle after its address.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else begin
            vld_p1  <= (state == S_READ);
            last_p1 <= (state == S_READ) && at_last;
        end
    end

    assign rd_valid    = vld_p1;
    assign rd_last     = last_p1;
    assign rd_data     = sram_o_data;
    assign sram_i_data = wr_data;
    assign busy        = (state != S_IDLE) || vld_p1;

endmodule
